// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle FP add/sub (align, add, normalize) over a shared shifter,
// with valid/ready handshakes on both sides and truncating, flush-to-zero arithmetic.
module fp_add_sequencer #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [EXP_W+MAN_W:0]     y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t r_state, w_next;
  logic             r_sign_a, r_sign_b, r_sign, r_sub, r_inf, r_inf_sign, r_ovf, r_unf;
  logic [EXP_W-1:0] r_exp_a, r_exp_b, r_exp;
  logic [SW-1:0]    r_sig_a, r_sig_b;
  logic [SW:0]      r_sum;
  logic [EXP_W-1:0] w_exp_in_a, w_exp_in_b, w_exp_l, w_exp_s, w_delta, w_exp_inc, w_exp_dec;
  logic [SW-1:0]    w_sig_l, w_sig_s, w_sig_al;
  logic             w_a_big, w_done, w_ovf, w_norm_end;
  assign w_exp_in_a = a[W-2:MAN_W];
  assign w_exp_in_b = b[W-2:MAN_W];
  assign w_a_big    = {r_exp_a, r_sig_a} >= {r_exp_b, r_sig_b};
  assign w_exp_l    = w_a_big ? r_exp_a : r_exp_b;
  assign w_exp_s    = w_a_big ? r_exp_b : r_exp_a;
  assign w_sig_l    = w_a_big ? r_sig_a : r_sig_b;
  assign w_sig_s    = w_a_big ? r_sig_b : r_sig_a;
  assign w_delta    = w_exp_l - w_exp_s;
  assign w_sig_al   = (int'(w_delta) >= SW) ? '0 : w_sig_s >> w_delta;
  assign w_exp_inc  = r_exp + 1'b1;
  assign w_exp_dec  = r_exp - 1'b1;
  assign w_norm_end = r_sum[SW] | r_sum[MAN_W] | (r_sum == '0) | (w_exp_dec == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? ALIGN : IDLE;
      ALIGN:   w_next = ADD;
      ADD:     w_next = NORM;
      NORM:    w_next = w_norm_end ? DONE : NORM;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_done    = r_state == DONE;
    w_ovf     = r_ovf | r_inf;
    in_ready  = r_state == IDLE;
    out_valid = w_done;
    overflow  = w_done & w_ovf;
    underflow = w_done & r_unf;
    y = !w_done ? '0
      : w_ovf   ? {r_inf ? r_inf_sign : r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
      :           {r_sign, r_exp, r_sum[MAN_W-1:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_sign_a, r_sign_b, r_sign, r_sub, r_inf, r_inf_sign, r_ovf, r_unf} <= '0;
      r_exp_a <= '0;
      r_exp_b <= '0;
      r_exp   <= '0;
      r_sig_a <= '0;
      r_sig_b <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_sign_a   <= a[W-1];
          r_sign_b   <= b[W-1];
          r_exp_a    <= w_exp_in_a;
          r_exp_b    <= w_exp_in_b;
          r_sig_a    <= (w_exp_in_a == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
          r_sig_b    <= (w_exp_in_b == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
          r_inf      <= (&w_exp_in_a) | (&w_exp_in_b);
          r_inf_sign <= (&w_exp_in_a) ? a[W-1] : b[W-1];
          r_ovf      <= 1'b0;
          r_unf      <= 1'b0;
        end
        ALIGN: begin
          r_sig_a <= w_sig_l;
          r_sig_b <= w_sig_al;
          r_exp   <= w_exp_l;
          r_sign  <= w_a_big ? r_sign_a : r_sign_b;
          r_sub   <= r_sign_a ^ r_sign_b;
        end
        ADD: r_sum <= r_sub ? {1'b0, r_sig_a} - {1'b0, r_sig_b} : {1'b0, r_sig_a} + {1'b0, r_sig_b};
        NORM:
          if (r_sum[SW]) begin
            r_sum <= r_sum >> 1;
            r_exp <= w_exp_inc;
            r_ovf <= &w_exp_inc;
          end else if (r_sum[MAN_W]) begin
            r_sum <= r_sum;
          end else if (r_sum == '0) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
          end else begin
            r_sum <= (w_exp_dec == '0) ? '0 : r_sum << 1;
            r_exp <= w_exp_dec;
            r_unf <= w_exp_dec == '0;
          end
        default: r_sum <= r_sum;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: scoreboard bench; the driver queues model results at accept, a
// negedge monitor compares each presented result, its latency and its hold stability.
module tb_fp_add_sequencer;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [15:0] a = 0, b = 0, y;
  logic        in_ready, out_valid, overflow, underflow;
  int          checks = 0, errors = 0, cyc = 0;
  bit          bp_hold = 0;
  typedef struct {logic [15:0] y; bit ov; bit un; int lat; int acc;} exp_t;
  exp_t sb[$];

  fp_add_sequencer dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask

  // Reference: value-level add with flush-to-zero, truncating alignment and normalization.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] z);
    exp_t r;
    int ex = int'(x[14:10]), ez = int'(z[14:10]);
    int sx = (ex == 0) ? 0 : 1024 + int'(x[9:0]);
    int sz = (ez == 0) ? 0 : 1024 + int'(z[9:0]);
    bit xl = (ex > ez) || (ex == ez && sx >= sz);
    int el = xl ? ex : ez, es = xl ? ez : ex, sl = xl ? sx : sz, ss = xl ? sz : sx;
    bit sgn = xl ? x[15] : z[15];
    int d = el - es;
    int al = (d >= 11) ? 0 : (ss >> d);
    int sum = (x[15] == z[15]) ? sl + al : sl - al;
    int e = el, k = 0;
    logic [31:0] ev, sv;
    r.ov = 0; r.un = 0; r.lat = 3; r.acc = 0;
    if (sum >= 2048) begin
      sum = sum / 2; e++; r.ov = (e == 31);
    end else if (sum >= 1024) begin
      r.lat = 3;
    end else if (sum == 0) begin
      sgn = 0; e = 0;
    end else begin
      while (sum < 1024 && !r.un) begin
        sum = sum * 2; e--; k++;
        if (e == 0) begin r.un = 1; sum = 0; end
      end
      r.lat = r.un ? 2 + k : 3 + k;
    end
    ev = e; sv = sum;
    r.y = r.ov ? {sgn, 5'h1f, 10'h0} : {sgn, ev[4:0], sv[9:0]};
    if (ex == 31 || ez == 31) begin
      r.ov = 1;
      r.y  = {(ex == 31) ? x[15] : z[15], 5'h1f, 10'h0};
    end
    return r;
  endfunction

  task automatic issue(input logic [15:0] x, input logic [15:0] z, input bit push);
    int t = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("issue_timeout", 0, 1);
    a = x; b = z; in_valid = 1;
    if (push) begin e = model(x, z); e.acc = cyc + 1; sb.push_back(e); end
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("drain_timeout", 0, 1);
  endtask

  initial forever begin
    @(posedge clk);
    #1 out_ready = bp_hold ? 1'b0 : ($urandom % 3 != 0);
  end

  initial begin : monitor
    bit seen = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 0;
      else if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) chk("spurious_valid", out_valid, 0);
          else begin
            cur = sb.pop_front();
            chk("y", y, cur.y);
            chk("overflow", overflow, cur.ov);
            chk("underflow", underflow, cur.un);
            chk("latency", cyc - cur.acc, cur.lat);
          end
          seen = 1;
        end else begin
          chk("hold_y", y, cur.y);
          chk("hold_flags", {overflow, underflow}, {cur.ov, cur.un});
        end
        if (out_ready) seen = 0;
      end
    end
  end

  initial begin
    logic [15:0] dir[16] = '{16'h3C00,16'h3C00, 16'h3C00,16'h1000, 16'h3C00,16'hBBFF,
      16'h3C00,16'hBC00, 16'h0400,16'h8000, 16'h7BFF,16'h7BFF, 16'h0400,16'h8401,
      16'h0400,16'h83FF};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", {overflow, underflow}, 0);
    rst_n = 1;
    for (int i = 0; i < 16; i += 2) issue(dir[i], dir[i+1], 1);
    issue(16'h7C00, 16'hBC00, 1);
    issue(16'hFC00, 16'h7C00, 1);
    drain();
    bp_hold = 1;
    issue(16'h3C00, 16'h3C00, 1);
    begin
      int t = 0;
      while (!out_valid && t < 50) begin @(negedge clk); t++; end
      chk("bp_valid_seen", out_valid, 1);
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    bp_hold = 0;
    drain();
    issue(16'h3C00, 16'hBBFF, 0);
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_y", y, 0);
    chk("abort_flags", {overflow, underflow}, 0);
    @(negedge clk) rst_n = 1;
    repeat (20) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    for (int i = 0; i < 300; i++) begin
      logic [15:0] x, z;
      int e;
      x = 16'($urandom); z = 16'($urandom);
      if ($urandom % 2) begin
        e = int'(x[14:10]) + int'($urandom_range(0, 2)) - 1;
        e = (e < 0) ? 0 : (e > 31) ? 31 : e;
        z[14:10] = 5'(e);
        if ($urandom % 2) z[9:0] = x[9:0] ^ 10'($urandom_range(0, 7));
      end
      issue(x, z, 1);
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
